// File: rtl/bash_cmd_endpoint.sv
// bash_cmd_endpoint
//   Executor-side end of the bash line protocol. It copies one typed line
//   from the terminal into a local buffer and presents it to the command
//   executor. Response bytes go back to the terminal through a byte FIFO.
//   The block then closes the command with the solved handshake, or it asks
//   the terminal for one more input line.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   term_rx_ready/len/char    incoming line from the terminal (char 0 = end)
//   term_rx_next              1-cycle pulse: terminal advances to next byte
//   term_tx_ready/char        response byte offered to the terminal (0 = EOL)
//   term_tx_next              terminal consumed term_tx_char
//   term_solved(+_ack)        command finished, held until acknowledged
//   term_req_line(+_ack)      executor wants an input line, held until ack
//   cmd_valid/is_input/len    stored line presented to the executor
//   cmd_rd_addr/rd_data       combinational buffer read port
//   resp_push/char/full       executor side of the response FIFO
//   exec_done/exec_need_line  executor strobes, only meaningful in CMD
//   fsm_state                 current FSM state, for observation
//
// Handshake semantics: term_tx_char is transferred in the cycle in which
// term_tx_ready and term_tx_next are both 1. term_tx_next while
// term_tx_ready is 0 has no effect. resp_push is accepted when the FIFO is
// not full, or when a pop happens in the same cycle. Pushes are accepted
// only outside the IDLE and receive states.
module bash_cmd_endpoint #(
    parameter int BUF_LEN    = 128,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        term_rx_ready,
    input  logic [12:0] term_rx_len,
    input  logic [7:0]  term_rx_char,
    output logic        term_rx_next,
    output logic        term_tx_ready,
    output logic [7:0]  term_tx_char,
    input  logic        term_tx_next,
    output logic        term_solved,
    input  logic        term_solved_ack,
    output logic        term_req_line,
    input  logic        term_req_ack,
    output logic        cmd_valid,
    output logic        cmd_is_input,
    output logic [7:0]  cmd_len,
    input  logic [6:0]  cmd_rd_addr,
    output logic [7:0]  cmd_rd_data,
    input  logic        resp_push,
    input  logic [7:0]  resp_char,
    output logic        resp_full,
    input  logic        exec_done,
    input  logic        exec_need_line,
    output logic [2:0]  fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BA = $clog2(BUF_LEN);
    localparam logic [12:0] BUF_LEN_W = 13'(BUF_LEN);
    localparam logic [7:0]  BUF_LEN_B = 8'(BUF_LEN);
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RX_SAMPLE = 3'd1;
    localparam logic [2:0] S_RX_GAP    = 3'd2;
    localparam logic [2:0] S_CMD       = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_SOLVE     = 3'd5;
    localparam logic [2:0] S_REQ       = 3'd6;

    logic [2:0]    state;
    logic [12:0]   rx_cnt;
    logic          rx_gap;      // 1 = first gap cycle, 0 = last gap cycle
    logic          done_flag;   // DRAIN exits to SOLVE (1) or REQ (0)
    logic [7:0]    buf_mem [BUF_LEN];

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [1:0]    eol_gap;

    logic          rx_end;
    logic          rx_adv;
    logic          fifo_empty;
    logic          tx_active;
    logic          push_state;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // ---------------- receive path ----------------
    assign rx_end = (term_rx_char == 8'h00) || (rx_cnt == term_rx_len) || !term_rx_ready;
    assign rx_adv = (state == S_RX_SAMPLE) && !rx_end;
    assign term_rx_next = rx_adv;

    // Bytes past BUF_LEN are still consumed from the terminal. They are not stored.
    always_ff @(posedge clk) begin
        if (rx_adv && (rx_cnt < BUF_LEN_W)) begin
            buf_mem[rx_cnt[BA-1:0]] <= term_rx_char;
        end
    end

    assign cmd_len     = (rx_cnt >= BUF_LEN_W) ? BUF_LEN_B : rx_cnt[7:0];
    assign cmd_rd_data = ({1'b0, cmd_rd_addr} < cmd_len) ? buf_mem[cmd_rd_addr] : 8'h00;

    // ---------------- response FIFO ----------------
    assign fifo_empty    = (fifo_cnt == '0);
    assign resp_full     = (fifo_cnt == FIFO_FULL);
    assign tx_active     = (state == S_CMD) || (state == S_DRAIN);
    assign head          = fifo_mem[rd_ptr];
    assign term_tx_ready = tx_active && !fifo_empty && (eol_gap == 2'd0);
    assign term_tx_char  = term_tx_ready ? head : 8'h00;
    assign pop           = term_tx_ready && term_tx_next;
    assign push_state    = (state == S_CMD) || (state == S_DRAIN) ||
                           (state == S_SOLVE) || (state == S_REQ);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign push          = resp_push && push_state && (!resp_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= resp_char;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            eol_gap  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            // After the terminal takes an end-of-line byte it needs two idle cycles.
            if (pop && (head == 8'h00)) begin
                eol_gap <= 2'd2;
            end else if (eol_gap != 2'd0) begin
                eol_gap <= eol_gap - 2'd1;
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rx_cnt       <= 13'd0;
            rx_gap       <= 1'b0;
            done_flag    <= 1'b0;
            cmd_is_input <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (term_rx_ready) begin
                        state  <= S_RX_SAMPLE;
                        rx_cnt <= 13'd0;
                    end
                end
                S_RX_SAMPLE: begin
                    if (rx_end) begin
                        state <= S_CMD;
                    end else begin
                        if (rx_cnt != 13'h1FFF) begin
                            rx_cnt <= rx_cnt + 13'd1;
                        end
                        rx_gap <= 1'b1;
                        state  <= S_RX_GAP;
                    end
                end
                S_RX_GAP: begin
                    // The terminal updates its byte index one cycle after the
                    // pulse. Two idle cycles make sure a fresh byte is sampled.
                    if (!rx_gap) begin
                        state <= S_RX_SAMPLE;
                    end else begin
                        rx_gap <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (exec_done) begin
                        done_flag <= 1'b1;
                        state     <= S_DRAIN;
                    end else if (exec_need_line) begin
                        done_flag <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && (eol_gap == 2'd0)) begin
                        state <= done_flag ? S_SOLVE : S_REQ;
                    end
                end
                S_SOLVE: begin
                    if (term_solved_ack) begin
                        cmd_is_input <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (term_req_ack) begin
                        cmd_is_input <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid     = (state == S_CMD);
    assign term_solved   = (state == S_SOLVE);
    assign term_req_line = (state == S_REQ);
    assign fsm_state     = state;

endmodule

// File: tb/tb_bash_cmd_endpoint.sv
// Bench for bash_cmd_endpoint: terminal line source, executor driver,
// terminal response sink and a queue model of the response FIFO.
module tb_bash_cmd_endpoint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        term_rx_ready = 1'b0;
    logic [12:0] term_rx_len = 13'd0;
    logic [7:0]  term_rx_char;
    logic        term_rx_next;
    logic        term_tx_ready;
    logic [7:0]  term_tx_char;
    logic        term_tx_next = 1'b0;
    logic        term_solved;
    logic        term_solved_ack = 1'b0;
    logic        term_req_line;
    logic        term_req_ack = 1'b0;
    logic        cmd_valid;
    logic        cmd_is_input;
    logic [7:0]  cmd_len;
    logic [6:0]  cmd_rd_addr = 7'd0;
    logic [7:0]  cmd_rd_data;
    logic        resp_push = 1'b0;
    logic [7:0]  resp_char = 8'h00;
    logic        resp_full;
    logic        exec_done = 1'b0;
    logic        exec_need_line = 1'b0;
    logic [2:0]  fsm_state;

    bash_cmd_endpoint #(.BUF_LEN(128), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .term_rx_ready(term_rx_ready), .term_rx_len(term_rx_len),
        .term_rx_char(term_rx_char), .term_rx_next(term_rx_next),
        .term_tx_ready(term_tx_ready), .term_tx_char(term_tx_char),
        .term_tx_next(term_tx_next),
        .term_solved(term_solved), .term_solved_ack(term_solved_ack),
        .term_req_line(term_req_line), .term_req_ack(term_req_ack),
        .cmd_valid(cmd_valid), .cmd_is_input(cmd_is_input), .cmd_len(cmd_len),
        .cmd_rd_addr(cmd_rd_addr), .cmd_rd_data(cmd_rd_data),
        .resp_push(resp_push), .resp_char(resp_char), .resp_full(resp_full),
        .exec_done(exec_done), .exec_need_line(exec_need_line),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- terminal line source ----------------
    logic [7:0] line_mem [256];
    int rx_len_i = 0;
    int rx_idx = 0;
    int rx_pulses = 0;
    int rx_last = 0;
    int rx_gap_bad = 0;

    assign term_rx_char = (rx_idx < rx_len_i) ? line_mem[rx_idx[7:0]] : 8'h00;

    initial begin : rx_term
        forever begin
            @(negedge clk);
            if (term_rx_next === 1'b1) begin
                if (rx_pulses > 0 && (cyc - rx_last) < 3) rx_gap_bad++;
                rx_pulses++;
                rx_last = cyc;
                @(posedge clk);
                #1;
                rx_idx++;
            end
        end
    end

    // ---------------- response FIFO model + terminal sink ----------------
    logic [7:0] exp_q[$];
    int eol_cyc = -100;
    bit mon_en = 1'b0;
    bit sink_en = 1'b0;
    bit one_pop = 1'b0;

    initial begin : tx_mon
        int sz;
        bit exp_rdy;
        bit do_pop;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                sz = exp_q.size();
                exp_rdy = (sz > 0) && ((cyc - eol_cyc) >= 3);
                check("tx_ready", term_tx_ready, exp_rdy);
                check("resp_full", resp_full, sz >= 16);
                if (exp_rdy) check("tx_char", term_tx_char, exp_q[0]);
                do_pop = exp_rdy && (one_pop || (sink_en && $urandom_range(0, 3) != 0));
                one_pop = 1'b0;
                // Spurious consume strobes while nothing is offered must be ignored.
                term_tx_next = do_pop || (sink_en && sz == 0 && $urandom_range(0, 7) == 0);
                if (do_pop) begin
                    if (exp_q[0] == 8'h00) eol_cyc = cyc;
                    void'(exp_q.pop_front());
                end
                if (resp_push && (sz < 16 || do_pop)) exp_q.push_back(resp_char);
            end else begin
                term_tx_next = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit is_in = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input int limit, input string tag);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            case (which)
                0:       hit = cmd_valid;
                1:       hit = term_solved;
                default: hit = term_req_line;
            endcase
            if (hit) break;
        end
        check({tag, "_reached"}, hit, 1);
    endtask

    task automatic send_line(input int len);
        int exp_cnt;
        int el;
        exp_cnt = len;
        for (int i = len - 1; i >= 0; i--) if (line_mem[i] == 8'h00) exp_cnt = i;
        el = (exp_cnt > 128) ? 128 : exp_cnt;
        rx_idx = 0;
        rx_len_i = len;
        rx_pulses = 0;
        rx_gap_bad = 0;
        tick();
        term_rx_len = 13'(len);
        term_rx_ready = 1'b1;
        wait_sig(0, 4 * len + 50, "rx");
        term_rx_ready = 1'b0;
        check("rx_pulses", rx_pulses, exp_cnt);
        check("rx_spacing", rx_gap_bad, 0);
        check("cmd_len", cmd_len, el);
        check("cmd_is_input", cmd_is_input, is_in);
        for (int a = 0; a < 128; a++) begin
            cmd_rd_addr = 7'(a);
            #1;
            check("cmd_rd_data", cmd_rd_data, (a < el) ? line_mem[a] : 8'h00);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tick();
        resp_push = 1'b1;
        resp_char = b;
        tick();
        resp_push = 1'b0;
    endtask

    task automatic finish_cmd(input bit d, input bit nl);
        bit to_solve;
        to_solve = d;
        tick();
        term_solved_ack = 1'b1;
        term_req_ack = 1'b1;
        tick();
        term_solved_ack = 1'b0;
        term_req_ack = 1'b0;
        @(negedge clk);
        check("ack_ignored_in_cmd", cmd_valid, 1);
        tick();
        exec_done = d;
        exec_need_line = nl;
        tick();
        exec_done = 1'b0;
        exec_need_line = 1'b0;
        @(negedge clk);
        check("cmd_valid_drop", cmd_valid, 0);
        if (to_solve) wait_sig(1, 600, "solved");
        else wait_sig(2, 600, "req_line");
        check("drain_empty", exp_q.size(), 0);
        check("drain_eol_gap", (cyc - eol_cyc) >= 3, 1);
        check("other_hs_low", to_solve ? term_req_line : term_solved, 0);
        repeat ($urandom_range(1, 3)) begin
            tick();
            if (to_solve) term_req_ack = 1'b1;
            else term_solved_ack = 1'b1;
            tick();
            term_req_ack = 1'b0;
            term_solved_ack = 1'b0;
            @(negedge clk);
            check("hs_held", to_solve ? term_solved : term_req_line, 1);
        end
        tick();
        if (to_solve) term_solved_ack = 1'b1;
        else term_req_ack = 1'b1;
        tick();
        term_solved_ack = 1'b0;
        term_req_ack = 1'b0;
        @(negedge clk);
        check("hs_release", term_solved | term_req_line, 0);
        is_in = !to_solve;
        check("is_input_after", cmd_is_input, is_in);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_next"}, term_rx_next, 0);
        check({tag, "_tx_ready"}, term_tx_ready, 0);
        check({tag, "_tx_char"}, term_tx_char, 0);
        check({tag, "_solved"}, term_solved, 0);
        check({tag, "_req_line"}, term_req_line, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_is_input"}, cmd_is_input, 0);
        check({tag, "_cmd_len"}, cmd_len, 0);
        check({tag, "_rd_data"}, cmd_rd_data, 0);
        check({tag, "_resp_full"}, resp_full, 0);
        check({tag, "_state"}, fsm_state, 0);
    endtask

    task automatic random_line(input int len);
        for (int i = 0; i < 256; i++) line_mem[i] = 8'($urandom_range(1, 255));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int len;
        bit d;
        cmd_rd_addr = 7'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #2 rst = 1'b0;
        mon_en = 1'b1;
        sink_en = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // "ls"
        line_mem[0] = 8'h6C;
        line_mem[1] = 8'h73;
        send_line(2);
        finish_cmd(1, 0);

        // 200-byte line, truncated to 128 stored bytes
        random_line(200);
        send_line(200);
        finish_cmd(1, 0);

        // empty line
        line_mem[0] = 8'h00;
        send_line(0);
        finish_cmd(1, 0);

        // "hi\0ok\0" response stream
        line_mem[0] = 8'h78;
        send_line(1);
        push_byte(8'h68); push_byte(8'h69); push_byte(8'h00);
        push_byte(8'h6F); push_byte(8'h6B); push_byte(8'h00);
        finish_cmd(1, 0);

        // FIFO fill: 17 pushes without pops, then pop+push while full
        line_mem[0] = 8'h66;
        send_line(1);
        sink_en = 1'b0;
        for (int i = 0; i < 17; i++) push_byte(8'($urandom_range(1, 255)));
        @(negedge clk);
        check("fill_full", resp_full, 1);
        check("fill_model_cnt", exp_q.size(), 16);
        tick();
        resp_push = 1'b1;
        resp_char = 8'h5A;
        one_pop = 1'b1;
        tick();
        resp_push = 1'b0;
        @(negedge clk);
        check("full_push_pop", resp_full, 1);
        sink_en = 1'b1;
        // both strobes in one cycle: done wins
        finish_cmd(1, 1);

        // input request, then "5"
        line_mem[0] = 8'h72; line_mem[1] = 8'h75; line_mem[2] = 8'h6E;
        send_line(3);
        finish_cmd(0, 1);
        line_mem[0] = 8'h35;
        send_line(1);
        finish_cmd(0, 1);

        // reset in the middle of a receive gap
        random_line(10);
        rx_idx = 0; rx_len_i = 10; rx_pulses = 0;
        tick();
        term_rx_len = 13'd10;
        term_rx_ready = 1'b1;
        for (int n = 0; n < 200 && rx_pulses < 3; n++) @(negedge clk);
        check("rst_setup_pulses", rx_pulses, 3);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rx_reset");
        term_rx_ready = 1'b0;
        exp_q.delete();
        eol_cyc = -100;
        is_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        rx_idx = 0;
        mon_en = 1'b1;

        // randomized commands
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(0, 150);
            random_line(len);
            if (len > 0 && $urandom_range(0, 3) == 0) line_mem[$urandom_range(0, len - 1)] = 8'h00;
            send_line(len);
            repeat ($urandom_range(0, 24)) begin
                push_byte(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            end
            d = 1'($urandom_range(0, 1));
            finish_cmd(d, !d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
